// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // Odd parity holds when the byte plus its parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Synchronizes the raw PS/2 pins, debounces the clock line and flags its falling edges.
module ps2_input_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_filt,
  output logic fe,
  output logic data_sync
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync_q;
  logic [CW-1:0] cnt;
  logic          clk_filt_d;

  // The filtered clock only follows the synced pin after FILTER_LEN samples in a row disagree with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync    <= 2'b11;
      data_sync_q <= 2'b11;
      cnt         <= '0;
      clk_filt    <= 1'b1;
      clk_filt_d  <= 1'b1;
      fe          <= 1'b0;
    end else begin
      clk_sync    <= {clk_sync[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      if (clk_sync[1] == clk_filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      clk_filt_d <= clk_filt;
      fe         <= clk_filt_d & ~clk_filt;
    end
  end

  assign data_sync = data_sync_q[1];

endmodule

// File: rtl/ps2_rx_deserializer.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
module ps2_rx_deserializer
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     rx_en,
  output logic [PS2_DATA_BITS-1:0] data_out,
  output logic                     data_valid,
  output logic                     parity_err,
  output logic                     frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic fe;
  logic sdata;
  logic clk_filt_unused;

  ps2_state_t               state_q, state_d;
  logic [PS2_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [2:0]               cnt_q, cnt_d;
  logic                     par_q, par_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [PS2_DATA_BITS-1:0] dout_d;
  logic                     dv_d, pe_d, fr_d;

  ps2_input_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .clk_filt (clk_filt_unused),
    .fe       (fe),
    .data_sync(sdata)
  );

  // Priority: rx_en abort, then a clock edge, then the idle-line timeout.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    dout_d  = data_out;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    fr_d    = 1'b0;
    timer_d = (state_q == IDLE || fe) ? '0 : timer_q + 1'b1;

    if (!rx_en) begin
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
      timer_d = '0;
    end else if (fe) begin
      unique case (state_q)
        IDLE: begin
          if (!sdata) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shreg_d = {sdata, shreg_q[PS2_DATA_BITS-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == 3'(PS2_DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          par_d   = sdata;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!sdata) begin
            fr_d = 1'b1;
          end else if (odd_parity_ok(shreg_q, par_q)) begin
            dout_d = shreg_q;
            dv_d   = 1'b1;
          end else begin
            pe_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && timer_q == TW'(TIMEOUT_CYCLES)) begin
      state_d = IDLE;
      fr_d    = 1'b1;
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      par_q      <= 1'b0;
      timer_q    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      par_q      <= par_d;
      timer_q    <= timer_d;
      data_out   <= dout_d;
      data_valid <= dv_d;
      parity_err <= pe_d;
      frame_err  <= fr_d;
    end
  end

endmodule

// File: tb/tb_ps2_rx_deserializer.sv
// Self-checking bench: drives PS/2 frames and predicts each frame's outcome and timing from its bits.
module tb_ps2_rx_deserializer;

  localparam int FL   = 4;
  localparam int TO   = 200;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rx_en = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err;

  ps2_rx_deserializer #(
    .FILTER_LEN(FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_en     (rx_en),
    .data_out  (data_out),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = good byte, 1 = parity error, 2 = frame error
  typedef struct {
    int         kind;
    logic [7:0] val;
    int         cmin;
    int         cmax;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] model_dout = 8'h00;
  int         compared = 0;
  int         mismatched = 0;
  int         dv_cnt = 0, pe_cnt = 0, fr_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Every cycle out of reset: pulse exclusivity, pulse kind and timing against the queue, data_out hold.
  always @(negedge clk) begin
    int   np;
    int   kind_act;
    exp_t e;
    if (reset) begin
      np = int'(data_valid) + int'(parity_err) + int'(frame_err);
      if (data_valid) dv_cnt++;
      if (parity_err) pe_cnt++;
      if (frame_err)  fr_cnt++;
      if (np > 1) checkOutput("one_pulse_at_a_time", np, 1);
      if (np != 0) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_pulse", np, 0);
        end else begin
          e        = expq.pop_front();
          kind_act = data_valid ? 0 : (parity_err ? 1 : 2);
          checkOutput("pulse_kind", kind_act, e.kind);
          compared++;
          if (cyc < e.cmin || cyc > e.cmax) begin
            mismatched++;
            $display("[TB] FAIL pulse_cycle: got cycle %0d, expected %0d..%0d", cyc, e.cmin, e.cmax);
          end
          if (e.kind == 0) model_dout = e.val;
        end
      end else if (expq.size() != 0 && cyc > expq[0].cmax) begin
        checkOutput("missing_pulse", 0, 1);
        void'(expq.pop_front());
      end
      checkOutput("data_out", data_out, model_dout);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bit i of a frame falls HALF cycles into its slot; raises the clock HALF cycles later.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (glitch && i == 2) begin
        wait_clk(8);
        ps2_clk = 1'b0;
        wait_clk(1);
        ps2_clk = 1'b1;
        wait_clk(HALF - 9);
      end else begin
        wait_clk(HALF);
      end
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] val, input bit par_good, input bit stop, input bit glitch);
    logic        p;
    logic [10:0] bits;
    exp_t        e;
    p      = par_good ? ~^val : ^val;
    bits   = {stop, p, val, 1'b0};
    e.val  = val;
    e.kind = !stop ? 2 : (par_good ? 0 : 1);
    // stop bit falls at 21*HALF; 2 sync + FL filter + edge reg + output reg
    e.cmin = cyc + 21 * HALF + 4 + FL;
    e.cmax = e.cmin;
    expq.push_back(e);
    send_bits(bits, 11, glitch);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    expq.delete();
    model_dout = 8'h00;
    @(negedge clk);
    checkOutput("reset_data_out", data_out, 8'h00);
    checkOutput("reset_pulses", {data_valid, parity_err, frame_err}, 3'b000);
    wait_clk(2);
    reset = 1'b1;
    wait_clk(2);
  endtask

  initial begin
    int d_dv, d_pe, d_fr;
    int t0;
    exp_t e;

    do_reset();
    wait_clk(10);

    d_dv = dv_cnt; d_pe = pe_cnt; d_fr = fr_cnt;
    applyStimulus(8'h1C, 1, 1, 0);
    wait_clk(10);
    checkOutput("t1_dv_count", dv_cnt - d_dv, 1);
    checkOutput("t1_err_count", (pe_cnt - d_pe) + (fr_cnt - d_fr), 0);
    checkOutput("t1_data", data_out, 8'h1C);

    d_dv = dv_cnt;
    applyStimulus(8'hAB, 1, 1, 0);
    applyStimulus(8'hFF, 1, 1, 0);
    wait_clk(10);
    checkOutput("t2_dv_count", dv_cnt - d_dv, 2);
    checkOutput("t2_data", data_out, 8'hFF);

    d_dv = dv_cnt; d_pe = pe_cnt;
    applyStimulus(8'hAA, 0, 1, 0);
    wait_clk(10);
    checkOutput("t3_pe_count", pe_cnt - d_pe, 1);
    checkOutput("t3_dv_count", dv_cnt - d_dv, 0);
    checkOutput("t3_data_held", data_out, 8'hFF);

    d_dv = dv_cnt; d_fr = fr_cnt;
    applyStimulus(8'h55, 1, 0, 0);
    wait_clk(10);
    checkOutput("t4_fr_count", fr_cnt - d_fr, 1);
    checkOutput("t4_dv_count", dv_cnt - d_dv, 0);

    // Start plus three data bits, then the line goes quiet.
    d_fr = fr_cnt;
    t0 = cyc;
    e.kind = 2; e.val = 8'h00;
    e.cmin = t0 + 7 * HALF + TO;
    e.cmax = e.cmin + FL + 12;
    expq.push_back(e);
    send_bits(11'b000_0000_1010, 4, 0);
    wait_clk(250);
    checkOutput("t5_timeout_fr_count", fr_cnt - d_fr, 1);
    d_dv = dv_cnt;
    applyStimulus(8'h1C, 1, 1, 0);
    wait_clk(10);
    checkOutput("t5_recover_dv", dv_cnt - d_dv, 1);
    checkOutput("t5_recover_data", data_out, 8'h1C);

    d_dv = dv_cnt;
    applyStimulus(8'h1C, 1, 1, 1);
    wait_clk(10);
    checkOutput("glitch_dv_count", dv_cnt - d_dv, 1);

    send_bits(11'b000_0011_0100, 5, 0);
    do_reset();
    d_dv = dv_cnt;
    applyStimulus(8'h3A, 1, 1, 0);
    wait_clk(10);
    checkOutput("t6_reset_recover_dv", dv_cnt - d_dv, 1);
    checkOutput("t6_reset_recover_data", data_out, 8'h3A);

    d_dv = dv_cnt; d_pe = pe_cnt; d_fr = fr_cnt;
    send_bits(11'b000_1100_1010, 5, 0);
    rx_en = 1'b0;
    wait_clk(1);
    rx_en = 1'b1;
    wait_clk(300);
    checkOutput("t6_rxen_no_pulse", (dv_cnt - d_dv) + (pe_cnt - d_pe) + (fr_cnt - d_fr), 0);
    checkOutput("t6_rxen_data_held", data_out, 8'h3A);
    applyStimulus(8'h3A, 1, 1, 0);
    wait_clk(10);
    checkOutput("t6_rxen_recover_dv", dv_cnt - d_dv, 1);

    for (int i = 0; i < 30; i++) begin
      applyStimulus(8'($urandom), $urandom_range(0, 4) != 0, $urandom_range(0, 9) != 0,
                    $urandom_range(0, 2) == 0);
      wait_clk($urandom_range(HALF, 3 * HALF));
    end
    wait_clk(50);
    checkOutput("queue_drained", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
